rv32i_decode_issue: RTL and testbench
=====================================

// Module: rv32i_decode_issue
// PURPOSE
//  Decode/issue stage: accepts fetched RV32I words, decodes them, reads the 2R1W register file and drives the execute-stage ALU.
//  ALU-facing outputs are a, b, aluop, funct3 and funct7, plus immediate/rd/pc sideband, behind one registered valid/ready slot.
//  Sits between fetch and execute; write-back returns through the wb_* port.
// PARAMETERS
//  XLEN       32  datapath width; only 32 is supported
//  RF_RST_EN  1   1: regfile cleared on reset; 0: contents undefined until written
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  in_valid     in   1   fetch presents instruction
//  in_ready     out  1   stage accepts instruction this cycle
//  in_instr     in   32  instruction word
//  in_pc        in   32  instruction address
//  out_valid    out  1   issue slot holds a valid instruction
//  out_ready    in   1   execute consumes slot this cycle
//  ex_a         out  32  ALU operand a
//  ex_b         out  32  ALU operand b
//  ex_aluop     out  7   ALU op (opcode encoding)
//  ex_funct3    out  3   instr[14:12]
//  ex_funct7    out  7   instr[31:25] for R-type/shifts; 0 otherwise
//  ex_imm       out  32  sign-extended immediate (branch/jump target, store offset)
//  ex_rs2_data  out  32  rs2 value (store data)
//  ex_rd        out  5   destination register
//  ex_rd_we     out  1   writes rd; forced 0 when rd==0 or illegal
//  ex_pc        out  32  pc of issued instruction
//  ex_illegal   out  1   unsupported opcode
//  flush        in   1   redirect: squash slot and incoming instruction
//  wb_we        in   1   write-back enable
//  wb_rd        in   5   write-back register
//  wb_data      in   32  write-back data
// BEHAVIOUR
//  Reset: out_valid=0; all ex_* outputs=0; in_ready=0 during reset, 1 the first cycle after.
//  Handshake: in_ready = !flush & (!out_valid | out_ready). Transfer on in_valid&in_ready.
//   Decoded results register on transfer; latency 1 cycle from accept to out_valid.
//  Slot: out_valid set on transfer. It clears when out_ready occurs with no new transfer.
//   With out_valid&!out_ready, all ex_* hold stable.
//  flush: out_valid<=0 next cycle regardless of out_ready; in_instr that cycle is dropped; flush beats reset? no — reset wins.
//  Operand mapping (opcode -> a, b, aluop):
//   OP 0110011       a=rs1, b=rs2, aluop=opcode
//   OP-IMM 0010011   a=rs1, b=immI, aluop=opcode; shifts keep funct7=instr[31:25]
//   LOAD 0000011     a=rs1, b=immI, aluop=opcode
//   STORE 0100011    a=rs1, b=immS, aluop=opcode
//   BRANCH 1100011   a=rs1, b=rs2, aluop=opcode; ex_imm=immB
//   LUI              a=0,  b=immU, aluop=7'b0010111 (add)
//   AUIPC            a=pc, b=immU, aluop=opcode
//   JAL/JALR         a=pc, b=4,   aluop=7'b0010111 (link value); ex_imm=immJ/immI
//   other opcodes    ex_illegal=1, ex_rd_we=0, a=b=0
//  Immediate widths: I/S 12b, B 13b (bit0=0), J 21b (bit0=0); all sign-extended to 32. U = instr[31:12]<<12.
//  Regfile: x0 reads 0 and ignores writes. Write occurs at clk edge when wb_we.
//  Simultaneous write-back and read of the same register: see CONFIGURATION.
// CONFIGURATION
//  DECODE_WB_BYPASS_EN defined: read of wb_rd while wb_we returns wb_data in the same cycle (never for x0).
//  DECODE_WB_BYPASS_EN undefined: the same read returns the old stored value; the hazard is handled upstream.
// STRUCTURE
//  Shared package rv32i_pkg: opcode constants (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC,
//   OPC_JAL, OPC_JALR), ALU_ADD_OP=7'b0010111, an immediate-format enum (IMM_I/S/B/U/J).
//  Sub-module regfile_2r1w: 32x32 registers, 2 combinational read ports, 1 write port, holds the bypass mux.
// TESTING
//  1. wb x1=5, x2=7; issue ADD x3,x1,x2 (0x002081B3) -> next cycle out_valid=1, a=5, b=7, aluop=0x33, funct3=0, funct7=0, rd=3, rd_we=1.
//  2. ADDI x4,x0,-1 (0xFFF00213) -> a=0, b=0xFFFFFFFF, aluop=0x13; LUI x5,0x12345 -> a=0, b=0x12345000, aluop=0x17.
//  3. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ex_* stable; out_ready=1 -> next instr issued following cycle.
//  4. flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle; dropped instr never appears.
//  5. wb_we=1 wb_rd=1 wb_data=0xAA while issuing ADD x3,x1,x1 -> a=b=0xAA with DECODE_WB_BYPASS_EN, old x1 without.
//  6. wb to x0=0xFF then read x0 -> 0; opcode 0x7F -> ex_illegal=1, ex_rd_we=0; reset mid-stall -> out_valid=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats, issue-slot payload.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] ALU_ADD_OP = 7'b0010111;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  aluop;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] pc;
    logic        illegal;
  } issue_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two combinational reads, one write; x0 hardwired to zero.
// Optional same-cycle write-to-read bypass under DECODE_WB_BYPASS_EN.
module regfile_2r1w #(
  parameter int unsigned XLEN      = 32,
  parameter bit          RF_RST_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [4:0]      i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data
);

  logic [XLEN-1:0] r_regs [0:31];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_wr_addr != 5'd0);

  generate
    if (RF_RST_EN) begin : g_rst
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
          r_regs[i_wr_addr] <= i_wr_data;
        end
      end
    end else begin : g_norst
      // Contents stay undefined until written; writes are simply blocked while in reset.
      always_ff @(posedge clk) begin
        if (!reset && w_wr_en) r_regs[i_wr_addr] <= i_wr_data;
      end
    end
  endgenerate

  always_comb begin
    o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
    o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];
`ifdef DECODE_WB_BYPASS_EN
    if (w_wr_en && (i_rs1_addr == i_wr_addr)) o_rs1_data = i_wr_data;
    if (w_wr_en && (i_rs2_addr == i_wr_addr)) o_rs2_data = i_wr_data;
`endif
  end

endmodule

// File: rtl/rv32i_decode_issue.sv
// RV32I decode/issue stage: decodes, reads the register file and holds one registered issue slot.
// Build option DECODE_WB_BYPASS_EN enables same-cycle write-back forwarding in the register file.
module rv32i_decode_issue
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          RF_RST_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [6:0]      ex_aluop,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic            w_writes_rd;
  logic            w_xfer;
  issue_t          w_dec;
  issue_t          r_issue;
  logic            r_out_valid;

  regfile_2r1w #(
    .XLEN      (XLEN),
    .RF_RST_EN (RF_RST_EN)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (in_instr[19:15]),
    .i_rs2_addr (in_instr[24:20]),
    .o_rs1_data (w_rs1),
    .o_rs2_data (w_rs2),
    .i_we       (wb_we),
    .i_wr_addr  (wb_rd),
    .i_wr_data  (wb_data)
  );

  assign w_opcode = in_instr[6:0];
  assign w_imm_i  = imm_gen(in_instr, IMM_I);
  assign w_imm_s  = imm_gen(in_instr, IMM_S);
  assign w_imm_b  = imm_gen(in_instr, IMM_B);
  assign w_imm_u  = imm_gen(in_instr, IMM_U);
  assign w_imm_j  = imm_gen(in_instr, IMM_J);

  always_comb begin
    w_dec          = '0;
    w_writes_rd    = 1'b1;
    w_dec.aluop    = w_opcode;
    w_dec.funct3   = in_instr[14:12];
    w_dec.rd       = in_instr[11:7];
    w_dec.pc       = in_pc;
    w_dec.rs2_data = w_rs2;
    case (w_opcode)
      OPC_OP: begin
        w_dec.a      = w_rs1;
        w_dec.b      = w_rs2;
        w_dec.funct7 = in_instr[31:25];
      end
      OPC_OPIMM: begin
        w_dec.a   = w_rs1;
        w_dec.b   = w_imm_i;
        w_dec.imm = w_imm_i;
        // SLLI/SRLI/SRAI: funct7 distinguishes logical vs arithmetic shift
        if (in_instr[13:12] == 2'b01) w_dec.funct7 = in_instr[31:25];
      end
      OPC_LOAD: begin
        w_dec.a   = w_rs1;
        w_dec.b   = w_imm_i;
        w_dec.imm = w_imm_i;
      end
      OPC_STORE: begin
        w_dec.a     = w_rs1;
        w_dec.b     = w_imm_s;
        w_dec.imm   = w_imm_s;
        w_writes_rd = 1'b0;
      end
      OPC_BRANCH: begin
        w_dec.a     = w_rs1;
        w_dec.b     = w_rs2;
        w_dec.imm   = w_imm_b;
        w_writes_rd = 1'b0;
      end
      OPC_LUI: begin
        w_dec.b     = w_imm_u;
        w_dec.imm   = w_imm_u;
        w_dec.aluop = ALU_ADD_OP;
      end
      OPC_AUIPC: begin
        w_dec.a   = in_pc;
        w_dec.b   = w_imm_u;
        w_dec.imm = w_imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        w_dec.a     = in_pc;
        w_dec.b     = 32'd4;
        w_dec.aluop = ALU_ADD_OP;
        w_dec.imm   = (w_opcode == OPC_JAL) ? w_imm_j : w_imm_i;
      end
      default: begin
        w_dec.illegal = 1'b1;
        w_writes_rd   = 1'b0;
      end
    endcase
    w_dec.rd_we = w_writes_rd && (in_instr[11:7] != 5'd0);
  end

  assign in_ready = !reset && !flush && (!r_out_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_issue     <= '0;
    end else begin
      if (flush)          r_out_valid <= 1'b0;
      else if (w_xfer)    r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;
      if (w_xfer) r_issue <= w_dec;
    end
  end

  assign out_valid   = r_out_valid;
  assign ex_a        = r_issue.a;
  assign ex_b        = r_issue.b;
  assign ex_aluop    = r_issue.aluop;
  assign ex_funct3   = r_issue.funct3;
  assign ex_funct7   = r_issue.funct7;
  assign ex_imm      = r_issue.imm;
  assign ex_rs2_data = r_issue.rs2_data;
  assign ex_rd       = r_issue.rd;
  assign ex_rd_we    = r_issue.rd_we;
  assign ex_pc       = r_issue.pc;
  assign ex_illegal  = r_issue.illegal;

endmodule

// File: tb/tb_rv32i_decode_issue.sv
// Directed bench for rv32i_decode_issue; expectations follow DECODE_WB_BYPASS_EN when defined.
module tb_rv32i_decode_issue;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, flush, wb_we;
  logic [31:0] in_instr, in_pc, ex_a, ex_b, ex_imm, ex_rs2_data, ex_pc, wb_data;
  logic [6:0]  ex_aluop, ex_funct7;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd, wb_rd;
  logic        ex_rd_we, ex_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rv32i_decode_issue dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_aluop    (ex_aluop),
    .ex_funct3   (ex_funct3),
    .ex_funct7   (ex_funct7),
    .ex_imm      (ex_imm),
    .ex_rs2_data (ex_rs2_data),
    .ex_rd       (ex_rd),
    .ex_rd_we    (ex_rd_we),
    .ex_pc       (ex_pc),
    .ex_illegal  (ex_illegal),
    .flush       (flush),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    wb_we = 1'b1; wb_rd = rd; wb_data = data;
    tick();
    wb_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ex_a", ex_a, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD x3,x1,x2 after write-backs
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    issue(32'h002081B3, 32'h100);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_a", ex_a, 32'd5);
    chk("add_b", ex_b, 32'd7);
    chk("add_aluop", {25'd0, ex_aluop}, 32'h33);
    chk("add_f3f7", {22'd0, ex_funct3, ex_funct7}, 32'd0);
    chk("add_rd", {26'd0, ex_rd, ex_rd_we}, {26'd0, 5'd3, 1'b1});
    chk("add_pc", ex_pc, 32'h100);

    // ADDI x4,x0,-1 and LUI x5,0x12345
    issue(32'hFFF00213, 32'h104);
    chk("addi_a", ex_a, 32'd0);
    chk("addi_b", ex_b, 32'hFFFF_FFFF);
    chk("addi_aluop", {25'd0, ex_aluop}, 32'h13);
    chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
    issue(32'h123452B7, 32'h108);
    chk("lui_a", ex_a, 32'd0);
    chk("lui_b", ex_b, 32'h1234_5000);
    chk("lui_aluop", {25'd0, ex_aluop}, 32'h17);

    // Stall 3 cycles with ADD x6,x1,x2 waiting
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00208333; in_pc = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_b", ex_b, 32'h1234_5000);
      chk("stall_rd", {27'd0, ex_rd}, 32'd5);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("unstall_rd", {27'd0, ex_rd}, 32'd6);
    chk("unstall_ab", {ex_a[15:0], ex_b[15:0]}, {16'd5, 16'd7});
    chk("unstall_pc", ex_pc, 32'h10C);

    // SRAI x7,x1,1 keeps funct7
    issue(32'h4010D393, 32'h110);
    chk("srai_b", ex_b, 32'h401);
    chk("srai_f3f7", {22'd0, ex_funct3, ex_funct7}, {22'd0, 3'd5, 7'h20});

    // Flush with slot valid and ADDI x8,x0,1 presented
    in_valid = 1'b1; in_instr = 32'h00100413; in_pc = 32'h114; flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("flush_dropped", {31'd0, out_valid}, 32'd0);
    chk("flush_not_captured", {27'd0, ex_rd}, 32'd7);

    // Write-back to x1 while reading x1 twice
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hAA;
    issue(32'h001081B3, 32'h118);
    wb_we = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    chk("byp_a", ex_a, 32'hAA);
    chk("byp_b", ex_b, 32'hAA);
`else
    chk("nobyp_a", ex_a, 32'd5);
    chk("nobyp_b", ex_b, 32'd5);
`endif
    issue(32'h001081B3, 32'h11C);
    chk("after_wb_a", ex_a, 32'hAA);

    // x0 write ignored, also in the same cycle as a read
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
    issue(32'h000001B3, 32'h120);
    wb_we = 1'b0;
    chk("x0_same_cycle", ex_a | ex_b, 32'd0);
    issue(32'h000001B3, 32'h124);
    chk("x0_read", ex_a | ex_b, 32'd0);

    // ADD x0,x1,x2: rd_we suppressed
    issue(32'h00208033, 32'h128);
    chk("rd0_we", {31'd0, ex_rd_we}, 32'd0);

    // Illegal opcode 0x7F
    issue(32'h000000FF, 32'h12C);
    chk("ill_flag", {30'd0, ex_illegal, ex_rd_we}, 32'b10);
    chk("ill_ab", ex_a | ex_b, 32'd0);

    // BEQ x1,x2,+8
    issue(32'h00208463, 32'h130);
    chk("beq_ab", {ex_a[15:0], ex_b[15:0]}, {16'hAA, 16'd7});
    chk("beq_imm", ex_imm, 32'd8);
    chk("beq_we", {31'd0, ex_rd_we}, 32'd0);

    // SW x2,12(x1)
    issue(32'h0020A623, 32'h134);
    chk("sw_b", ex_b, 32'd12);
    chk("sw_data", ex_rs2_data, 32'd7);
    chk("sw_aluop_we", {24'd0, ex_aluop, ex_rd_we}, {24'd0, 7'h23, 1'b0});

    // JAL x1,-4
    issue(32'hFFDFF0EF, 32'h200);
    chk("jal_ab", {ex_a[15:0], ex_b[15:0]}, {16'h200, 16'd4});
    chk("jal_imm", ex_imm, 32'hFFFF_FFFC);
    chk("jal_aluop", {25'd0, ex_aluop}, 32'h17);

    // AUIPC x5,1
    issue(32'h00001297, 32'h300);
    chk("auipc_a", ex_a, 32'h300);
    chk("auipc_b", ex_b, 32'h1000);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    issue(32'h00208333, 32'h400);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_ex_a", ex_a, 32'd0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
